// File: rtl/dma_arb_if.sv
// Requester-side and engine-register-side signals of the DMA engine arbiter.
// The master modport is the arbiter. The slave modport is the requesters plus the engine.
interface dma_arb_if;
  logic [3:0]  req;
  logic [71:0] rq_addr;
  logic [7:0]  rq_ctrl;
  logic [63:0] rq_wdata;
  logic [3:0]  ack;
  logic [15:0] rsp_rdata;
  logic        rsp_fail;
  logic        busy;
  logic [1:0]  cur_grant;
  logic        sl_write;
  logic [2:0]  sl_waddr;
  logic [31:0] sl_wdata;
  logic [2:0]  sl_raddr;
  logic [31:0] sl_rdata;

  modport master (
    input  req, rq_addr, rq_ctrl, rq_wdata, sl_rdata,
    output ack, rsp_rdata, rsp_fail, busy, cur_grant,
           sl_write, sl_waddr, sl_wdata, sl_raddr
  );

  modport slave (
    output req, rq_addr, rq_ctrl, rq_wdata, sl_rdata,
    input  ack, rsp_rdata, rsp_fail, busy, cur_grant,
           sl_write, sl_waddr, sl_wdata, sl_raddr
  );
endinterface

// File: rtl/dma_arb.sv
// Round-robin arbiter sharing the switch/light DMA engine among four requesters.
// Each transfer runs lock -> data -> start -> poll -> fetch -> unlock.
module dma_arb #(
  parameter logic [31:0] LOCKKEY = 32'h41524231,
  parameter int          RETRY   = 64,
  parameter int          WDOG    = 4095
) (
  input logic       CLOCK,
  input logic       RESET,
  dma_arb_if.master bus
);
  localparam int BO_W = $clog2(RETRY + 1);
  localparam int WD_W = $clog2(WDOG + 1);

  typedef enum logic [3:0] {
    IDLE, LOCK, LCHK, BACKOFF, LDAT, START, SETTLE, POLL, FETCH, UNLK
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n, grant, grant_n;
  logic [BO_W-1:0] bo_cnt, bo_n;
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic            fail_q, fail_n;
  logic            take;
  logic [17:0]     addr_q;
  logic [1:0]      ctrl_q;
  logic [15:0]     wdata_q;
  logic [3:0]      ack_q, ack_n;
  logic [15:0]     rdata_q, rdata_n;
  logic            rfail_q, rfail_n;
  logic            busy_q, busy_n;
  logic            wr_q, wr_n;
  logic [2:0]      waddr_q, waddr_n, raddr_q, raddr_n;
  logic [31:0]     wdat_q, wdat_n;
  logic [1:0]      pick, idx;
  logic            found;

  always_comb begin
    pick  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant;
    bo_n    = bo_cnt;
    wd_n    = wd_cnt;
    fail_n  = fail_q;
    rdata_n = rdata_q;
    take    = 1'b0;
    unique case (state)
      IDLE: if (found) begin
        grant_n = pick;
        take    = 1'b1;
        state_n = LOCK;
      end
      LOCK: state_n = LCHK;
      LCHK: if (bus.sl_rdata == LOCKKEY) state_n = LDAT;
            else begin
              bo_n    = BO_W'(RETRY);
              state_n = BACKOFF;
            end
      BACKOFF: begin
        bo_n = bo_cnt - BO_W'(1);
        if (bo_cnt <= BO_W'(1)) state_n = LOCK;
      end
      LDAT: state_n = START;
      START: begin
        wd_n    = '0;
        state_n = SETTLE;
      end
      SETTLE: state_n = POLL;
      POLL: if (bus.sl_rdata[31:29] == 3'd0) begin
              fail_n  = bus.sl_rdata[28];
              state_n = FETCH;
            end else if (wd_cnt == WD_W'(WDOG)) begin
              fail_n  = 1'b1;
              state_n = UNLK;
            end else begin
              wd_n = wd_cnt + WD_W'(1);
            end
      FETCH: begin
        if (!ctrl_q[1]) rdata_n = bus.sl_rdata[15:0];
        state_n = UNLK;
      end
      UNLK: begin
        ptr_n   = grant + 2'd1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    wr_n    = 1'b0;
    waddr_n = waddr_q;
    wdat_n  = wdat_q;
    raddr_n = 3'd0;
    ack_n   = 4'd0;
    rfail_n = rfail_q;
    busy_n  = (state_n != IDLE);
    case (state_n)
      LOCK: begin
        wr_n    = 1'b1;
        waddr_n = 3'd5;
        wdat_n  = LOCKKEY;
      end
      LCHK: raddr_n = 3'd5;
      LDAT: if (ctrl_q[1]) begin
        wr_n    = 1'b1;
        waddr_n = 3'd4;
        wdat_n  = {16'h0, wdata_q};
      end
      START: begin
        wr_n    = 1'b1;
        waddr_n = 3'd3;
        wdat_n  = {2'b00, 1'b1, 1'b0, ctrl_q, 8'h00, addr_q};
      end
      POLL:  raddr_n = 3'd3;
      FETCH: raddr_n = 3'd4;
      UNLK: begin
        wr_n    = 1'b1;
        waddr_n = 3'd5;
        wdat_n  = LOCKKEY;
        ack_n   = 4'b0001 << grant_n;
        rfail_n = fail_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      grant   <= 2'd0;
      bo_cnt  <= '0;
      wd_cnt  <= '0;
      fail_q  <= 1'b0;
      ack_q   <= 4'd0;
      rdata_q <= 16'h0;
      rfail_q <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      waddr_q <= 3'd0;
      wdat_q  <= 32'h0;
      raddr_q <= 3'd0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      grant   <= grant_n;
      bo_cnt  <= bo_n;
      wd_cnt  <= wd_n;
      fail_q  <= fail_n;
      ack_q   <= ack_n;
      rdata_q <= rdata_n;
      rfail_q <= rfail_n;
      busy_q  <= busy_n;
      wr_q    <= wr_n;
      waddr_q <= waddr_n;
      wdat_q  <= wdat_n;
      raddr_q <= raddr_n;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (take) begin
      addr_q  <= bus.rq_addr[int'(pick)*18 +: 18];
      ctrl_q  <= bus.rq_ctrl[int'(pick)*2 +: 2];
      wdata_q <= bus.rq_wdata[int'(pick)*16 +: 16];
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_fail  = rfail_q;
  assign bus.busy      = busy_q;
  assign bus.cur_grant = grant;
  assign bus.sl_write  = wr_q;
  assign bus.sl_waddr  = waddr_q;
  assign bus.sl_wdata  = wdat_q;
  assign bus.sl_raddr  = raddr_q;
endmodule
